// File: rtl/video_frame_align_fifo.sv
// Frame-aligning elastic FIFO between the video daisy chain and the VGA sync stage.
// Drops beats until a frame_start arrives so the sink always starts on pixel (0,0).
package video_frame_align_pkg;
  typedef struct packed {
    logic [9:0] hc;
    logic [9:0] vc;
    logic       frame_start;
  } vga_fc_t;
endpackage

module video_frame_align_fifo
  import video_frame_align_pkg::*;
#(
  parameter int RGB_SIZE = 12,
  parameter int AW       = 4,
  parameter int DCNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  vga_fc_t             src_fc,
  input  logic [RGB_SIZE-1:0] src_rgb,
  input  logic                src_vld,
  output logic                src_rdy,
  output vga_fc_t             snk_fc,
  output logic [RGB_SIZE-1:0] snk_rgb,
  output logic                snk_vld,
  input  logic                snk_rdy,
  output logic [AW:0]         level,
  output logic [DCNT_W-1:0]   drop_cnt
);

  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    vga_fc_t             fc;
    logic [RGB_SIZE-1:0] rgb;
  } entry_t;

  typedef enum logic {ALIGN, PASS} state_t;

  state_t      state_q, state_d;
  entry_t      mem [DEPTH];
  entry_t      head, last_q;
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty;
  logic        wr_en, rd_en, drop_inc;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign level = wr_ptr - rd_ptr;

  // Fall-through head; once drained the last popped entry stays visible.
  assign head    = mem[rd_ptr[AW-1:0]];
  assign snk_vld = !empty;
  assign snk_fc  = empty ? last_q.fc  : head.fc;
  assign snk_rgb = empty ? last_q.rgb : head.rgb;
  assign rd_en   = snk_vld && snk_rdy;

  always_comb begin
    state_d  = state_q;
    src_rdy  = 1'b1;
    wr_en    = 1'b0;
    drop_inc = 1'b0;
    case (state_q)
      ALIGN: begin
        if (src_vld) begin
          if (src_fc.frame_start) begin
            wr_en   = 1'b1;
            state_d = PASS;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      PASS: begin
        src_rdy = !full;
        wr_en   = src_vld && !full;
      end
      default: state_d = ALIGN;
    endcase
  end

  // Flush shares the reset path for pointers/state but leaves drop_cnt alone.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q <= ALIGN;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      state_q <= state_d;
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                   last_q <= '0;
    else if (!flush && rd_en)  last_q <= head;
  end

  always_ff @(posedge clk) begin
    if (rst)
      drop_cnt <= '0;
    else if (!flush && drop_inc && drop_cnt != {DCNT_W{1'b1}})
      drop_cnt <= drop_cnt + DCNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_en)
      mem[wr_ptr[AW-1:0]] <= '{fc: src_fc, rgb: src_rgb};
  end

endmodule
